// File: rtl/sel_scan.sv
// sel_scan: steps a 4:1 mux select through all channels, waits SETTLE cycles on each,
// and captures the settled samples into a 4-bit word reported with a one-cycle done pulse.
module sel_scan #(
    parameter int SETTLE = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic       din,
    output logic [1:0] sel,
    output logic [3:0] dout,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_SAMPLE, S_DONE} state_t;

    localparam logic [3:0] CNT_LAST = 4'(SETTLE - 1);

    state_t     state_q, state_d;
    logic [1:0] sel_q, sel_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] shadow_q, shadow_d;
    logic [3:0] dout_q, dout_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        dout_d   = dout_q;
        case (state_q)
            S_IDLE: begin
                sel_d = 2'd0;
                cnt_d = 4'd0;
                state_d = (start && !abort) ? S_SETTLE : S_IDLE;
            end
            S_SETTLE: begin
                if (abort) begin
                    state_d  = S_IDLE;
                    sel_d    = 2'd0;
                    cnt_d    = 4'd0;
                    shadow_d = 4'd0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_SAMPLE;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_SAMPLE: begin
                if (abort) begin
                    state_d  = S_IDLE;
                    sel_d    = 2'd0;
                    cnt_d    = 4'd0;
                    shadow_d = 4'd0;
                end else begin
                    shadow_d[sel_q] = din;
                    cnt_d = 4'd0;
                    // The last channel goes straight into dout alongside the stored bits
                    if (sel_q == 2'd3) begin
                        dout_d  = {din, shadow_q[2:0]};
                        state_d = S_DONE;
                    end else begin
                        sel_d   = sel_q + 2'd1;
                        state_d = S_SETTLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                sel_d   = 2'd0;
            end
        endcase
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            sel_q    <= 2'd0;
            cnt_q    <= 4'd0;
            shadow_q <= 4'd0;
            dout_q   <= 4'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            dout_q   <= dout_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign sel  = sel_q;
    assign dout = dout_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_sel_scan.sv
// tb_sel_scan: drives two sel_scan instances (SETTLE=1 and SETTLE=3) through a behavioural 4:1 mux;
// expected words are queued at each start and checked whenever done pulses.
module tb_sel_scan;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start_a = 1'b0, abort_a = 1'b0, start_b = 1'b0, abort_b = 1'b0;
    logic [3:0] mux_a = 4'd0, mux_b = 4'd0;
    logic       din_a, din_b;
    logic [1:0] sel_a, sel_b;
    logic [3:0] dout_a, dout_b;
    logic       busy_a, busy_b, done_a, done_b;

    int n_vec = 0;
    int n_err = 0;
    logic [3:0] q_a[$];
    logic [3:0] q_b[$];

    always #5 clk = ~clk;

    assign din_a = mux_a[sel_a];
    assign din_b = mux_b[sel_b];

    sel_scan #(.SETTLE(1)) u_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a), .din(din_a),
        .sel(sel_a), .dout(dout_a), .busy(busy_a), .done(done_a)
    );

    sel_scan #(.SETTLE(3)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b), .din(din_b),
        .sel(sel_b), .dout(dout_b), .busy(busy_b), .done(done_b)
    );

    always @(negedge clk) begin : mon
        logic [3:0] e;
        if (done_a) begin
            n_vec++;
            if (q_a.size() == 0) begin
                n_err++;
                $display("FAIL sb_a: unexpected done, dout=%b with no scan outstanding", dout_a);
            end else begin
                e = q_a.pop_front();
                if (dout_a !== e) begin
                    n_err++;
                    $display("FAIL sb_a: dout=%b expected %b", dout_a, e);
                end
            end
        end
        if (done_b) begin
            n_vec++;
            if (q_b.size() == 0) begin
                n_err++;
                $display("FAIL sb_b: unexpected done, dout=%b with no scan outstanding", dout_b);
            end else begin
                e = q_b.pop_front();
                if (dout_b !== e) begin
                    n_err++;
                    $display("FAIL sb_b: dout=%b expected %b", dout_b, e);
                end
            end
        end
    end

    task automatic test_reset;
        #2;
        n_vec++;
        if ({sel_a, busy_a, done_a, dout_a} !== 8'd0) begin
            n_err++;
            $display("FAIL reset_a: got %b want 00000000", {sel_a, busy_a, done_a, dout_a});
        end
        n_vec++;
        if ({sel_b, busy_b, done_b, dout_b} !== 8'd0) begin
            n_err++;
            $display("FAIL reset_b: got %b want 00000000", {sel_b, busy_b, done_b, dout_b});
        end
        @(negedge clk) rst_n = 1'b1;
    endtask

    task automatic test_basic;
        logic [7:0] exp;
        mux_a = 4'b0110;
        q_a.push_back(4'b0110);
        @(negedge clk) start_a = 1'b1;
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            start_a = 1'b0;
            exp = (j < 8) ? {2'(j / 2), 1'b1, 1'b0, 4'b0000} :
                  (j == 8) ? {2'd3, 1'b1, 1'b1, 4'b0110} : {2'd0, 1'b0, 1'b0, 4'b0110};
            n_vec++;
            if ({sel_a, busy_a, done_a, dout_a} !== exp) begin
                n_err++;
                $display("FAIL basic j=%0d: sel/busy/done/dout got %b want %b", j, {sel_a, busy_a, done_a, dout_a}, exp);
            end
        end
    endtask

    task automatic test_settle3;
        logic [7:0] exp;
        mux_b = 4'b1001;
        q_b.push_back(4'b1001);
        @(negedge clk) start_b = 1'b1;
        for (int j = 0; j < 18; j++) begin
            @(negedge clk);
            start_b = 1'b0;
            exp = (j < 16) ? {2'(j / 4), 1'b1, 1'b0, 4'b0000} :
                  (j == 16) ? {2'd3, 1'b1, 1'b1, 4'b1001} : {2'd0, 1'b0, 1'b0, 4'b1001};
            n_vec++;
            if ({sel_b, busy_b, done_b, dout_b} !== exp) begin
                n_err++;
                $display("FAIL settle3 j=%0d: sel/busy/done/dout got %b want %b", j, {sel_b, busy_b, done_b, dout_b}, exp);
            end
        end
    endtask

    task automatic test_abort;
        mux_a = 4'b0101;
        q_a.push_back(4'b0101);
        @(negedge clk) start_a = 1'b1;
        @(negedge clk) start_a = 1'b0;
        repeat (10) @(negedge clk);
        n_vec++;
        if (dout_a !== 4'b0101) begin
            n_err++;
            $display("FAIL abort_prior: dout got %b want 0101", dout_a);
        end
        mux_a = 4'b1111;
        @(negedge clk) start_a = 1'b1;
        @(negedge clk) start_a = 1'b0;
        repeat (4) @(negedge clk);
        n_vec++;
        if ({sel_a, busy_a} !== 3'b101) begin
            n_err++;
            $display("FAIL abort_ch2: sel/busy got %b want 101", {sel_a, busy_a});
        end
        abort_a = 1'b1;
        @(negedge clk) abort_a = 1'b0;
        n_vec++;
        if ({sel_a, busy_a, done_a, dout_a} !== 8'b0000_0101) begin
            n_err++;
            $display("FAIL abort_idle: sel/busy/done/dout got %b want 00000101", {sel_a, busy_a, done_a, dout_a});
        end
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            n_vec++;
            if ({busy_a, done_a, dout_a} !== 6'b00_0101) begin
                n_err++;
                $display("FAIL abort_hold j=%0d: busy/done/dout got %b want 000101", j, {busy_a, done_a, dout_a});
            end
        end
        start_a = 1'b1;
        abort_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        abort_a = 1'b0;
        n_vec++;
        if ({sel_a, busy_a} !== 3'b000) begin
            n_err++;
            $display("FAIL abort_wins: sel/busy got %b want 000", {sel_a, busy_a});
        end
    endtask

    task automatic test_ignore;
        logic [7:0] exp;
        mux_a = 4'b0011;
        q_a.push_back(4'b0011);
        @(negedge clk) start_a = 1'b1;
        for (int j = 0; j < 12; j++) begin
            @(negedge clk);
            exp = (j < 8) ? {2'(j / 2), 1'b1, 1'b0, 4'b0101} :
                  (j == 8) ? {2'd3, 1'b1, 1'b1, 4'b0011} : {2'd0, 1'b0, 1'b0, 4'b0011};
            n_vec++;
            if ({sel_a, busy_a, done_a, dout_a} !== exp) begin
                n_err++;
                $display("FAIL ignore j=%0d: sel/busy/done/dout got %b want %b", j, {sel_a, busy_a, done_a, dout_a}, exp);
            end
            start_a = (j == 1 || j == 8);
            abort_a = (j == 8);
        end
        start_a = 1'b0;
        abort_a = 1'b0;
    endtask

    task automatic test_back_to_back;
        int nd = 0;
        int idle = 0;
        int t[3] = '{0, 0, 0};
        mux_a = 4'b1010;
        repeat (3) q_a.push_back(4'b1010);
        @(negedge clk) start_a = 1'b1;
        for (int j = 0; j < 30; j++) begin
            @(negedge clk);
            if (done_a) begin
                if (nd < 3) t[nd] = j;
                nd++;
            end
            if (!busy_a) idle++;
        end
        start_a = 1'b0;
        repeat (4) @(negedge clk);
        n_vec++;
        if (nd != 3) begin
            n_err++;
            $display("FAIL b2b_count: done pulses got %0d want 3", nd);
        end
        n_vec++;
        if (t[0] != 8) begin
            n_err++;
            $display("FAIL b2b_first: first done at %0d want 8", t[0]);
        end
        n_vec++;
        if (t[1] - t[0] != 10 || t[2] - t[1] != 10) begin
            n_err++;
            $display("FAIL b2b_spacing: gaps got %0d,%0d want 10,10", t[1] - t[0], t[2] - t[1]);
        end
        n_vec++;
        if (idle != 3) begin
            n_err++;
            $display("FAIL b2b_idle: idle cycles got %0d want 3", idle);
        end
    endtask

    task automatic test_reset_mid;
        logic [7:0] exp;
        mux_a = 4'b1100;
        q_a.push_back(4'b1100);
        @(negedge clk) start_a = 1'b1;
        @(negedge clk) start_a = 1'b0;
        repeat (4) @(negedge clk);
        n_vec++;
        if (sel_a !== 2'd2) begin
            n_err++;
            $display("FAIL rstmid_pre: sel got %0d want 2", sel_a);
        end
        #2 rst_n = 1'b0;
        #1;
        q_a.delete();
        n_vec++;
        if ({sel_a, busy_a, done_a, dout_a} !== 8'd0) begin
            n_err++;
            $display("FAIL rstmid_async: sel/busy/done/dout got %b want 00000000", {sel_a, busy_a, done_a, dout_a});
        end
        @(negedge clk);
        rst_n = 1'b1;
        start_a = 1'b1;
        q_a.push_back(4'b1100);
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            start_a = 1'b0;
            exp = (j < 8) ? {2'(j / 2), 1'b1, 1'b0, 4'b0000} :
                  (j == 8) ? {2'd3, 1'b1, 1'b1, 4'b1100} : {2'd0, 1'b0, 1'b0, 4'b1100};
            n_vec++;
            if ({sel_a, busy_a, done_a, dout_a} !== exp) begin
                n_err++;
                $display("FAIL rstmid_scan j=%0d: sel/busy/done/dout got %b want %b", j, {sel_a, busy_a, done_a, dout_a}, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_settle3();
        test_abort();
        test_ignore();
        test_back_to_back();
        test_reset_mid();
        repeat (3) @(negedge clk);
        n_vec++;
        if (q_a.size() != 0 || q_b.size() != 0) begin
            n_err++;
            $display("FAIL sb_drain: outstanding a=%0d b=%0d want 0,0", q_a.size(), q_b.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
